// File: rtl/conv_deinterleaver.sv
// rtl/conv_deinterleaver.sv - convolutional byte deinterleaver, branch j delays (BRANCHES-1-j)*UNIT_DEPTH bytes
// Optional macro DEINT_SYNC_EN adds sync_in, which forces the commutator back to branch 0.

module conv_deinterleaver #(
  parameter int BRANCHES   = 12,
  parameter int UNIT_DEPTH = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       buf_en,
  input  logic [7:0] data_in,
`ifdef DEINT_SYNC_EN
  input  logic       sync_in,
`endif
  output logic [7:0] data_out,
  output logic       out_valid,
  output logic [3:0] branch_idx,
  output logic       fill_done
);

  localparam logic [11:0] FILL_MAX = 12'(BRANCHES * (BRANCHES - 1) * UNIT_DEPTH);
  localparam logic [3:0]  LAST_BR  = 4'(BRANCHES - 1);

  logic [3:0]  ptr;
  logic [3:0]  sel;
  logic [3:0]  ptr_nxt;
  logic        resync;
  logic [11:0] fill_cnt;
  logic [7:0]  tap [BRANCHES];

  always_comb begin
    sel    = ptr;
    resync = 1'b0;
`ifdef DEINT_SYNC_EN
    // A sync byte always lands on branch 0; only a real pointer jump restarts the fill.
    if (sync_in) begin
      sel    = 4'd0;
      resync = buf_en && (ptr != 4'd0);
    end
`endif
    ptr_nxt = (sel == LAST_BR) ? 4'd0 : sel + 4'd1;
  end

  for (genvar j = 0; j < BRANCHES; j++) begin : g_branch
    localparam int D = (BRANCHES - 1 - j) * UNIT_DEPTH;
    if (D == 0) begin : g_pass
      assign tap[j] = data_in;
    end else begin : g_sr
      logic [7:0] sr [D];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < D; k++) sr[k] <= 8'h00;
        end else if (buf_en && (sel == 4'(j))) begin
          sr[0] <= data_in;
          for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
        end
      end
      // Oldest byte of the branch, popped on the same edge that pushes data_in.
      assign tap[j] = sr[D-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr        <= 4'd0;
      data_out   <= 8'h00;
      out_valid  <= 1'b0;
      branch_idx <= 4'd0;
      fill_cnt   <= 12'd0;
      fill_done  <= 1'b0;
    end else begin
      out_valid <= buf_en;
      if (buf_en) begin
        ptr        <= ptr_nxt;
        data_out   <= tap[sel];
        branch_idx <= sel;
      end
      if (resync) begin
        fill_cnt  <= 12'd0;
        fill_done <= 1'b0;
      end else begin
        if (buf_en && (fill_cnt != FILL_MAX)) fill_cnt <= fill_cnt + 12'd1;
        if (fill_cnt == FILL_MAX) fill_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_deinterleaver.sv
// tb/tb_conv_deinterleaver.sv - directed and random checks of conv_deinterleaver against a stream-index model
// Default build (DEINT_SYNC_EN undefined).

module tb_conv_deinterleaver;

  localparam int I    = 12;
  localparam int M    = 17;
  localparam int FILL = I * (I - 1) * M;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       buf_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       out_valid;
  logic [3:0] branch_idx;
  logic       fill_done;

  int total = 0;
  int passed = 0;
  int fails = 0;

  logic [7:0] hist [$];
  int         n_acc = 0;
  logic [7:0] last_out = 8'h00;
  logic [3:0] last_idx = 4'd0;

  conv_deinterleaver #(.BRANCHES(I), .UNIT_DEPTH(M)) dut (
    .clk        (clk),
    .reset      (reset),
    .buf_en     (buf_en),
    .data_in    (data_in),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .branch_idx (branch_idx),
    .fill_done  (fill_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte n of the deinterleaver input leaves D*I stream positions later, D = branch depth.
  function automatic logic [7:0] model_out(input int n);
    int d;
    d = (I - 1 - (n % I)) * M * I;
    return (n >= d) ? hist[n - d] : 8'h00;
  endfunction

  function automatic logic [7:0] il_byte(input int n);
    int d;
    d = (n % I) * M * I;
    return (n >= d) ? 8'(n - d) : 8'h00;
  endfunction

  task automatic step(input logic en, input logic [7:0] d);
    logic exp_f;
    @(negedge clk);
    buf_en  = en;
    data_in = d;
    exp_f   = (n_acc >= FILL);
    if (en) begin
      hist.push_back(d);
      last_out = model_out(n_acc);
      last_idx = 4'(n_acc % I);
      n_acc++;
    end
    @(posedge clk);
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, en});
    chk("data_out", {24'd0, data_out}, {24'd0, last_out});
    chk("branch_idx", {28'd0, branch_idx}, {28'd0, last_idx});
    chk("fill_done", {31'd0, fill_done}, {31'd0, exp_f});
  endtask

  task automatic do_reset();
    @(negedge clk);
    buf_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_branch_idx", {28'd0, branch_idx}, 32'd0);
    chk("rst_fill_done", {31'd0, fill_done}, 32'd0);
    hist.delete();
    n_acc    = 0;
    last_out = 8'h00;
    last_idx = 4'd0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int acc;
    #2;
    chk("init_data_out", {24'd0, data_out}, 32'd0);
    chk("init_out_valid", {31'd0, out_valid}, 32'd0);
    chk("init_fill_done", {31'd0, fill_done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int n = 0; n < 12; n++) step(1'b1, 8'(n));
    chk("seq12_data", {24'd0, data_out}, 32'h0B);
    chk("seq12_idx", {28'd0, branch_idx}, 32'd11);

    while ((n_acc % I) != 10) step(1'b1, 8'($urandom));
    step(1'b1, 8'hA5);
    acc = 0;
    while (acc < 203) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom));
      else begin
        step(1'b1, 8'($urandom));
        acc++;
      end
    end
    step(1'b1, 8'($urandom));
    chk("a5_data", {24'd0, data_out}, 32'hA5);
    chk("a5_idx", {28'd0, branch_idx}, 32'd10);

    do_reset();
    for (int n = 0; n < FILL + 300; n++) begin
      step(1'b1, il_byte(n));
      if (n >= FILL) chk("e2e_cont", {24'd0, data_out}, {24'd0, 8'(n - FILL)});
    end

    do_reset();
    for (int n = 0; n < FILL + 100; n++) begin
      step(1'b1, il_byte(n));
      if (n >= FILL) chk("e2e_gap", {24'd0, data_out}, {24'd0, 8'(n - FILL)});
      step(1'b0, 8'($urandom));
    end

    do_reset();
    for (int n = 0; n < 1000; n++) step(1'($urandom_range(0, 4) != 0), 8'($urandom));
    do_reset();
    step(1'b1, 8'h3C);
    chk("post_rst_idx", {28'd0, branch_idx}, 32'd0);
    for (int n = 1; n < FILL + 20; n++) step(1'b1, 8'($urandom));
    chk("post_rst_fill", {31'd0, fill_done}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
